// File: rtl/markov_pipeline_sequencer_if.sv
// rtl/markov_pipeline_sequencer_if.sv - handshake bundle between the pipeline sequencer and its learner/merge units
interface markov_pipeline_sequencer_if #(
  parameter int NUM_LEARN  = 4,
  parameter int NUM_MERGE1 = 2
);

  logic                  start_i;
  logic [NUM_LEARN-1:0]  learn_start_o;
  logic [NUM_LEARN-1:0]  learn_done_i;
  logic [NUM_MERGE1-1:0] merge1_start_o;
  logic [NUM_MERGE1-1:0] merge1_done_i;
  logic                  merge2_start_o;
  logic                  merge2_done_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  error_o;
  logic [2:0]            stage_o;

  // Sequencer side: receives requests and unit done flags, drives start pulses and status
  modport master (
    input  start_i,
    input  learn_done_i,
    input  merge1_done_i,
    input  merge2_done_i,
    output learn_start_o,
    output merge1_start_o,
    output merge2_start_o,
    output busy_o,
    output done_o,
    output error_o,
    output stage_o
  );

  // Requester/unit side: the mirror image of the sequencer view
  modport slave (
    output start_i,
    output learn_done_i,
    output merge1_done_i,
    output merge2_done_i,
    input  learn_start_o,
    input  merge1_start_o,
    input  merge2_start_o,
    input  busy_o,
    input  done_o,
    input  error_o,
    input  stage_o
  );

endinterface

// File: rtl/markov_pipeline_sequencer.sv
// rtl/markov_pipeline_sequencer.sv - run sequencer for learners, first merges and second merge; optional stage timeout via SEQ_TIMEOUT_EN
module markov_pipeline_sequencer #(
  parameter int NUM_LEARN   = 4,
  parameter int NUM_MERGE1  = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int TO_BITS     = 13
) (
  input  logic                          clk,
  input  logic                          rst_n,
  markov_pipeline_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEARN  = 3'd1,
    ST_MERGE1 = 3'd2,
    ST_MERGE2 = 3'd3,
    ST_FIN    = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // Learner 2k and 2k+1 feed first-merge unit k, so the counts are tied together.
  if (NUM_MERGE1 * 2 != NUM_LEARN) begin : g_bad_pairing
    $error("NUM_MERGE1 must equal NUM_LEARN/2");
  end
  if ((TIMEOUT_CYC < 2) || (64'(TIMEOUT_CYC) >= (64'd1 << TO_BITS))) begin : g_bad_timeout
    $error("TO_BITS too narrow for TIMEOUT_CYC");
  end

  state_e                state_q, state_d;
  logic [NUM_LEARN-1:0]  learn_sticky_q, learn_sticky_d;
  logic [NUM_MERGE1-1:0] merge1_sticky_q, merge1_sticky_d;
  logic [NUM_LEARN-1:0]  learn_start_q, learn_start_d;
  logic [NUM_MERGE1-1:0] merge1_start_q, merge1_start_d;
  logic                  merge2_start_q, merge2_start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  learn_all;
  logic                  merge1_all;
  logic                  timeout_hit;
  logic                  entering;

  // A unit reporting done in the same cycle it is observed counts immediately.
  assign learn_all  = &(learn_sticky_q | bus.learn_done_i);
  assign merge1_all = &(merge1_sticky_q | bus.merge1_done_i);

`ifdef SEQ_TIMEOUT_EN
  logic [TO_BITS-1:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == TO_BITS'(TIMEOUT_CYC - 1));

  // Stage cycle counter: zero on entry, then counts up and saturates while a stage waits
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == ST_LEARN || state_q == ST_MERGE1 || state_q == ST_MERGE2)
                 && (cnt_q != {TO_BITS{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, sticky done capture and next values of every registered output
  always_comb begin
    state_d         = state_q;
    learn_sticky_d  = learn_sticky_q;
    merge1_sticky_d = merge1_sticky_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_i) state_d = ST_LEARN;
      end
      ST_LEARN: begin
        learn_sticky_d = learn_sticky_q | bus.learn_done_i;
        if (learn_all)        state_d = ST_MERGE1;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_MERGE1: begin
        merge1_sticky_d = merge1_sticky_q | bus.merge1_done_i;
        if (merge1_all)       state_d = ST_MERGE2;
        else if (timeout_hit) state_d = ST_ERR;
      end
      ST_MERGE2: begin
        if (bus.merge2_done_i) state_d = ST_FIN;
        else if (timeout_hit)  state_d = ST_ERR;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Each stage starts with a clean slate of done flags.
    entering = (state_d != state_q);
    if (entering && state_d == ST_LEARN)  learn_sticky_d  = '0;
    if (entering && state_d == ST_MERGE1) merge1_sticky_d = '0;

    learn_start_d  = (entering && state_d == ST_LEARN)  ? {NUM_LEARN{1'b1}}  : '0;
    merge1_start_d = (entering && state_d == ST_MERGE1) ? {NUM_MERGE1{1'b1}} : '0;
    merge2_start_d = entering && (state_d == ST_MERGE2);
    busy_d         = (state_d == ST_LEARN) || (state_d == ST_MERGE1) || (state_d == ST_MERGE2);
    done_d         = (state_d == ST_FIN);
`ifdef SEQ_TIMEOUT_EN
    error_d        = error_q || (state_d == ST_ERR);
`else
    error_d        = 1'b0;
`endif
  end

  // State, sticky flags and output registers; reset aborts any run in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      learn_sticky_q  <= '0;
      merge1_sticky_q <= '0;
      learn_start_q   <= '0;
      merge1_start_q  <= '0;
      merge2_start_q  <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      learn_sticky_q  <= learn_sticky_d;
      merge1_sticky_q <= merge1_sticky_d;
      learn_start_q   <= learn_start_d;
      merge1_start_q  <= merge1_start_d;
      merge2_start_q  <= merge2_start_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign bus.learn_start_o  = learn_start_q;
  assign bus.merge1_start_o = merge1_start_q;
  assign bus.merge2_start_o = merge2_start_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.error_o        = error_q;
  assign bus.stage_o        = state_q;

endmodule

// File: tb/tb_markov_pipeline_sequencer.sv
// tb/tb_markov_pipeline_sequencer.sv - self-checking bench for markov_pipeline_sequencer against a timeline model
module tb_markov_pipeline_sequencer;

  localparam int TB_TO = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  int   d_learn [4];
  int   d_m1    [2];
  int   d_m2;

  markov_pipeline_sequencer_if #(.NUM_LEARN(4), .NUM_MERGE1(2)) bus ();

  markov_pipeline_sequencer #(
    .NUM_LEARN(4), .NUM_MERGE1(2), .TIMEOUT_CYC(TB_TO), .TO_BITS(13)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic zero_inputs();
    bus.start_i       = 1'b0;
    bus.learn_done_i  = '0;
    bus.merge1_done_i = '0;
    bus.merge2_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    zero_inputs();
    bus.start_i = 1'b1;
    bus.learn_done_i = 4'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.learn_start_o, bus.merge1_start_o, bus.merge2_start_o, bus.busy_o,
         bus.done_o, bus.error_o, bus.stage_o} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0", {bus.learn_start_o, bus.merge1_start_o,
               bus.merge2_start_o, bus.busy_o, bus.done_o, bus.error_o, bus.stage_o});
    end
    zero_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stage_o !== 3'd0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle stage got %0d busy %b exp 0 0", bus.stage_o, bus.busy_o);
    end
  endtask

  // Drives one run from a start at cycle 0 and checks every output each cycle.
  // The model: each stage lasts (latest unit done offset + 1) cycles, FIN is one cycle.
  task automatic run_seq(input string name, input bit noise, input bit poke, input bit hold_learn);
    int l_e, m1_e, m2_e, f_e, mx, exp_stage, n_done;
    logic [3:0] ld;
    logic [1:0] md;
    logic       m2d;
    l_e = 1;
    mx  = 0;
    if (!hold_learn) foreach (d_learn[i]) if (d_learn[i] > mx) mx = d_learn[i];
    m1_e = l_e + mx + 1;
    mx = 0;
    foreach (d_m1[i]) if (d_m1[i] > mx) mx = d_m1[i];
    m2_e = m1_e + mx + 1;
    f_e  = m2_e + d_m2 + 1;
    n_done = 0;

    @(posedge clk); #1;
    zero_inputs();
    bus.start_i = 1'b1;
    if (hold_learn) bus.learn_done_i = 4'hF;

    for (int c = 1; c <= f_e + 2; c++) begin
      @(posedge clk); #1;
      bus.start_i = poke && (c == m1_e || c == f_e);
      ld = '0;
      if (hold_learn) ld = 4'hF;
      else if (noise && (c < l_e || c >= m1_e)) ld = 4'($urandom);
      else foreach (d_learn[i]) if (c == l_e + d_learn[i]) ld[i] = 1'b1;
      md = '0;
      if (noise && (c < m1_e || c >= m2_e)) md = 2'($urandom);
      else foreach (d_m1[i]) if (c == m1_e + d_m1[i]) md[i] = 1'b1;
      m2d = (c == m2_e + d_m2);
      if (noise && (c < m2_e || c >= f_e)) m2d = 1'($urandom);
      bus.learn_done_i  = ld;
      bus.merge1_done_i = md;
      bus.merge2_done_i = m2d;

      @(negedge clk);
      exp_stage = (c < m1_e) ? 1 : (c < m2_e) ? 2 : (c < f_e) ? 3 : (c == f_e) ? 4 : 0;
      if (bus.done_o === 1'b1) n_done++;
      n_checks++;
      if (bus.stage_o !== 3'(exp_stage)) begin
        n_fail++;
        $display("FAIL %s stage_o c=%0d got %0d exp %0d", name, c, bus.stage_o, exp_stage);
      end
      n_checks++;
      if (bus.busy_o !== (exp_stage >= 1 && exp_stage <= 3)) begin
        n_fail++;
        $display("FAIL %s busy_o c=%0d got %b exp %b", name, c, bus.busy_o,
                 (exp_stage >= 1 && exp_stage <= 3));
      end
      n_checks++;
      if (bus.learn_start_o !== ((c == l_e) ? 4'hF : 4'h0)) begin
        n_fail++;
        $display("FAIL %s learn_start_o c=%0d got %h exp %h", name, c, bus.learn_start_o,
                 (c == l_e) ? 4'hF : 4'h0);
      end
      n_checks++;
      if (bus.merge1_start_o !== ((c == m1_e) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL %s merge1_start_o c=%0d got %b exp %b", name, c, bus.merge1_start_o,
                 (c == m1_e) ? 2'b11 : 2'b00);
      end
      n_checks++;
      if (bus.merge2_start_o !== (c == m2_e)) begin
        n_fail++;
        $display("FAIL %s merge2_start_o c=%0d got %b exp %b", name, c, bus.merge2_start_o, (c == m2_e));
      end
      n_checks++;
      if (bus.done_o !== (c == f_e) || bus.error_o !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_o/error_o c=%0d got %b/%b exp %b/0", name, c, bus.done_o,
                 bus.error_o, (c == f_e));
      end
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL %s done_count got %0d exp 1", name, n_done);
    end
    zero_inputs();
  endtask

  task automatic test_basic();
    d_learn = '{3, 3, 3, 3};
    d_m1    = '{3, 3};
    d_m2    = 3;
    run_seq("basic", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_staggered();
    d_learn = '{1, 4, 6, 19};
    d_m1    = '{2, 0};
    d_m2    = 1;
    run_seq("staggered", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_held_done();
    d_learn = '{0, 0, 0, 0};
    d_m1    = '{1, 1};
    d_m2    = 1;
    run_seq("held_done", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_start_ignored();
    d_learn = '{3, 3, 3, 3};
    d_m1    = '{3, 3};
    d_m2    = 3;
    run_seq("start_ignored", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      foreach (d_learn[i]) d_learn[i] = int'($urandom_range(0, 6));
      foreach (d_m1[i])    d_m1[i]    = int'($urandom_range(0, 6));
      d_m2 = int'($urandom_range(0, 6));
      run_seq("random", 1'b1, 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    @(posedge clk); #1;
    zero_inputs();
    bus.start_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      bus.start_i      = 1'b0;
      bus.learn_done_i = (c == 1) ? 4'hF : 4'h0;
      bus.merge1_done_i = (c == 3) ? 2'b11 : 2'b00;
      bus.merge2_done_i = (c >= 4);
      rst_n = (c != 3);
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (bus.stage_o !== 3'd2) begin
          n_fail++;
          $display("FAIL rst_mid pre_stage got %0d exp 2", bus.stage_o);
        end
      end
      if (c >= 4) begin
        n_checks++;
        if ({bus.learn_start_o, bus.merge1_start_o, bus.merge2_start_o, bus.busy_o,
             bus.done_o, bus.error_o, bus.stage_o} !== 13'd0) begin
          n_fail++;
          $display("FAIL rst_mid outputs c=%0d got %b exp 0", c, {bus.learn_start_o,
                   bus.merge1_start_o, bus.merge2_start_o, bus.busy_o, bus.done_o,
                   bus.error_o, bus.stage_o});
        end
      end
    end
    zero_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    int e;
    @(posedge clk); #1;
    zero_inputs();
    bus.start_i = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    e = TB_TO + 1;
`else
    e = 1000;
`endif
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      bus.start_i      = (c == e + 3);
      bus.learn_done_i = (c == 1) ? 4'h7 : 4'h0;
      @(negedge clk);
      n_checks++;
      if (c < e) begin
        if (bus.stage_o !== 3'd1 || bus.busy_o !== 1'b1 || bus.error_o !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_wait c=%0d stage/busy/err got %0d/%b/%b exp 1/1/0", c,
                   bus.stage_o, bus.busy_o, bus.error_o);
        end
      end else begin
        if (bus.stage_o !== 3'd5 || bus.busy_o !== 1'b0 || bus.error_o !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_err c=%0d stage/busy/err got %0d/%b/%b exp 5/0/1", c,
                   bus.stage_o, bus.busy_o, bus.error_o);
        end
      end
      n_checks++;
      if (bus.learn_start_o !== ((c == 1) ? 4'hF : 4'h0) || bus.merge1_start_o !== 2'b00 ||
          bus.merge2_start_o !== 1'b0 || bus.done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_pulses c=%0d got %h/%b/%b/%b", c, bus.learn_start_o,
                 bus.merge1_start_o, bus.merge2_start_o, bus.done_o);
      end
    end
    zero_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stage_o !== 3'd0 || bus.error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_clear stage/err got %0d/%b exp 0/0", bus.stage_o, bus.error_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_staggered();
    test_held_done();
    test_start_ignored();
    test_reset_mid_run();
    test_random();
    test_timeout();
    test_basic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
